alu_mul_sequencer: RTL and testbench

- Operation initiator for the 16-bit combinational ALU: computes an unsigned 16x16 multiply (low 16 bits plus an overflow flag) by shift-and-add.
- Drives the ALU's a/b/opcode inputs one micro-op per cycle and registers its r/cout outputs.
- Sits between the datapath control (request/response handshake) and the shared ALU. The ALU is instantiated outside and wired to the alu_* ports.

---
 rtl/alu_mul_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// ============================================================================
// Module   : alu_mul_sequencer
// Purpose  : Shift-and-add unsigned multiplier that time-shares an external
//            combinational ALU; returns the low product bits plus overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mul_sequencer #(
  parameter int         WIDTH  = 16,
  parameter logic [3:0] OP_ADD = 4'h0,
  parameter logic [3:0] OP_SHL = 4'h3,
  parameter logic [3:0] OP_SHR = 4'h4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_product,
  output logic             resp_overflow,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_cout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHL   = 3'd3;
  localparam logic [2:0] S_SHR   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             r_ovf;
  logic             r_mc_hi;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_resp_product;
  logic             r_resp_overflow;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_opcode;
  logic [WIDTH-1:0] w_alu_a_nxt;
  logic [WIDTH-1:0] w_alu_b_nxt;
  logic [3:0]       w_alu_op_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (r_mplier == '0)   w_state_nxt = S_DONE;
        else if (r_mplier[0]) w_state_nxt = S_ADD;
        else                  w_state_nxt = S_SHL;
      end
      S_ADD:   w_state_nxt = S_SHL;
      S_SHL:   w_state_nxt = S_SHR;
      S_SHR:   w_state_nxt = S_CHECK;
      S_DONE:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are registered on entry to a micro-op state; the source registers
  // are never modified by the state being left, so current values are correct.
  always_comb begin
    w_alu_a_nxt  = '0;
    w_alu_b_nxt  = '0;
    w_alu_op_nxt = OP_ADD;
    case (w_state_nxt)
      S_ADD: begin
        w_alu_a_nxt = r_acc;
        w_alu_b_nxt = r_mcand;
      end
      S_SHL: begin
        w_alu_a_nxt  = r_mcand;
        w_alu_b_nxt  = WIDTH'(1);
        w_alu_op_nxt = OP_SHL;
      end
      S_SHR: begin
        w_alu_a_nxt  = r_mplier;
        w_alu_b_nxt  = WIDTH'(1);
        w_alu_op_nxt = OP_SHR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_acc           <= '0;
      r_mcand         <= '0;
      r_mplier        <= '0;
      r_ovf           <= 1'b0;
      r_mc_hi         <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_resp_product  <= '0;
      r_resp_overflow <= 1'b0;
      r_alu_a         <= '0;
      r_alu_b         <= '0;
      r_alu_opcode    <= OP_ADD;
    end else begin
      r_state      <= w_state_nxt;
      r_alu_a      <= w_alu_a_nxt;
      r_alu_b      <= w_alu_b_nxt;
      r_alu_opcode <= w_alu_op_nxt;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_mcand  <= req_a;
            r_mplier <= req_b;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_mc_hi  <= 1'b0;
          end
        end
        S_CHECK: begin
          if (r_mplier == '0) begin
            r_resp_valid    <= 1'b1;
            r_resp_product  <= r_acc;
            r_resp_overflow <= r_ovf;
          end
        end
        // mc_hi flags a multiplicand bit shifted past the top; any later add
        // of that multiplicand means the true product overflowed.
        S_ADD: begin
          r_acc <= alu_r;
          r_ovf <= r_ovf | alu_cout | r_mc_hi;
        end
        S_SHL: begin
          r_mcand <= alu_r;
          r_mc_hi <= r_mc_hi | r_mcand[WIDTH-1];
        end
        S_SHR: r_mplier <= alu_r;
        S_DONE: if (resp_ready) r_resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign resp_valid    = r_resp_valid;
  assign resp_product  = r_resp_product;
  assign resp_overflow = r_resp_overflow;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_opcode    = r_alu_opcode;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Purpose  : Self-checking bench for alu_mul_sequencer with a behavioural ALU
//            and an arithmetic product/latency reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_product;
  logic        resp_overflow;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_r;
  logic        alu_cout;

  int checks = 0;
  int errors = 0;

  alu_mul_sequencer #(.WIDTH(16), .OP_ADD(4'h0), .OP_SHL(4'h3), .OP_SHR(4'h4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_product(resp_product), .resp_overflow(resp_overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_r(alu_r), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Combinational 16-bit ALU as it would sit outside the sequencer.
  always_comb begin
    alu_r    = '0;
    alu_cout = 1'b0;
    case (alu_opcode)
      4'h0:    {alu_cout, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
      4'h3:    alu_r = alu_a << alu_b;
      4'h4:    alu_r = alu_a >> alu_b;
      default: alu_r = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [15:0] b);
    int          l = 1;
    logic [15:0] t = b;
    while (t != 0) begin
      l += 3 + int'(t[0]);
      t = t >> 1;
    end
    return l;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".product"}, 32'(resp_product), 32'd0);
    check({tag, ".overflow"}, 32'(resp_overflow), 32'd0);
    check({tag, ".alu_a"}, 32'(alu_a), 32'd0);
    check({tag, ".alu_b"}, 32'(alu_b), 32'd0);
    check({tag, ".alu_opcode"}, 32'(alu_opcode), 32'd0);
  endtask

  // Present a request at the falling edge; returns after the accepting rising edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_send", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [31:0] full;
    int          n;
    bit          alu_busy;
    logic [15:0] held_p;
    logic        held_o;
    full     = {16'b0, a} * {16'b0, b};
    send(a, b);
    n        = 0;
    alu_busy = 1'b0;
    check("req_ready_busy", 32'(req_ready), 32'd0);
    while (!resp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (alu_opcode !== 4'h0 || alu_a !== 16'h0 || alu_b !== 16'h0) alu_busy = 1'b1;
    end
    check("latency", 32'(n), 32'(exp_latency(b)));
    check("product", 32'(resp_product), {16'b0, full[15:0]});
    check("overflow", 32'(resp_overflow), 32'(full > 32'h0000_FFFF));
    if (b == 16'h0) check("zero_b_alu_idle", 32'(alu_busy), 32'd0);
    held_p = resp_product;
    held_o = resp_overflow;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_stable", {15'b0, resp_overflow, resp_product}, {15'b0, held_o, held_p});
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("consumed_valid", 32'(resp_valid), 32'd0);
    check("consumed_idle", 32'(req_ready), 32'd1);
    check("product_kept", 32'(resp_product), {16'b0, full[15:0]});
  endtask

  initial begin
    #12;
    check_reset_values("reset_low");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("reset_released");

    run_mul(16'd3, 16'd5, 0);
    run_mul(16'h1234, 16'h0000, 0);
    run_mul(16'hFFFF, 16'h0001, 0);
    run_mul(16'h0100, 16'h0100, 0);
    run_mul(16'h8000, 16'h0003, 0);
    run_mul(16'h00FF, 16'h0101, 0);
    run_mul(16'h00FF, 16'h0102, 0);
    run_mul(16'hFFFF, 16'hFFFF, 0);

    // Backpressure followed by an immediate back-to-back request.
    run_mul(16'h0ABC, 16'h0013, 10);
    run_mul(16'h0011, 16'h0022, 0);

    // Asynchronous reset while shifting the multiplicand.
    begin
      int n = 0;
      send(16'hFFFF, 16'hFFFF);
      while (alu_opcode !== 4'h3 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("reached_shl", 32'(alu_opcode), 32'h3);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("no_aborted_resp", 32'(resp_valid), 32'd0);
    end
    run_mul(16'd7, 16'd6, 0);

    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      case (i % 3)
        0:       rb = 16'($urandom);
        1:       rb = 16'($urandom_range(0, 255));
        default: rb = 16'($urandom_range(0, 7));
      endcase
      run_mul(ra, rb, i % 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
